// File: rtl/or_reduce_pipe.sv
// Pipelined OR unit: two-operand OR, OR-reduction tree and a sticky accumulator,
// LAT = log2(WIDTH) stages with a valid/ready handshake and a whole-pipe stall.
module or_reduce_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_any,
  output logic [WIDTH-1:0] acc_q
);

  localparam int LAT = $clog2(WIDTH);

  localparam logic [1:0] OP_OR2    = 2'b00;
  localparam logic [1:0] OP_REDUCE = 2'b01;
  localparam logic [1:0] OP_ACCUM  = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  if (WIDTH < 2 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("or_reduce_pipe: WIDTH must be a power of two in 2..64");
  end

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Level 0 is the live input; levels 1..LAT-1 are registers; the output register is level LAT.
  for (genvar gi = 0; gi < LAT; gi++) begin : g_st
    logic             v;
    logic [1:0]       o;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;

    if (gi == 0) begin : g_in
      assign v = in_valid;
      assign o = op;
      assign x = a;
      assign y = b;
    end else begin : g_reg
      logic [WIDTH-1:0] x_red;

      always_comb begin
        x_red = '0;
        for (int i = 0; i < (WIDTH >> gi); i++) begin
          x_red[i] = g_st[gi-1].x[2*i] | g_st[gi-1].x[2*i+1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v <= 1'b0;
          o <= '0;
          x <= '0;
          y <= '0;
        end else if (!stall) begin
          v <= g_st[gi-1].v;
          o <= g_st[gi-1].o;
          x <= (g_st[gi-1].o == OP_REDUCE) ? x_red : g_st[gi-1].x;
          y <= g_st[gi-1].y;
        end
      end
    end
  end

  logic [WIDTH-1:0] res;

  // Final level: the reduce tree has two live bits left at this point.
  always_comb begin
    res = '0;
    case (g_st[LAT-1].o)
      OP_OR2:    res = g_st[LAT-1].x | g_st[LAT-1].y;
      OP_REDUCE: res[0] = g_st[LAT-1].x[0] | g_st[LAT-1].x[1];
      OP_ACCUM:  res = acc_q | g_st[LAT-1].x;
      default:   res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      acc_q     <= '0;
    end else if (!stall) begin
      out_valid <= g_st[LAT-1].v;
      if (g_st[LAT-1].v) begin
        out_data <= res;
        if (g_st[LAT-1].o == OP_ACCUM || g_st[LAT-1].o == OP_CLEAR) begin
          acc_q <= res;
        end
      end
    end
  end

  assign out_any = |out_data;

endmodule

// File: tb/tb_or_reduce_pipe.sv
// Bench for or_reduce_pipe: directed table and corner sequences at WIDTH=8,
// randomized scoreboard runs at WIDTH=2 and WIDTH=64.
module tb_or_reduce_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // WIDTH=8 instance for directed tests
  logic       iv8, ir8, ov8, or8, any8;
  logic [1:0] op8;
  logic [7:0] a8, b8, od8, acc8;

  or_reduce_pipe #(.WIDTH(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op8),
    .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8), .out_data(od8),
    .out_any(any8), .acc_q(acc8)
  );

  // Random channels: index 0 is WIDTH=2, index 1 is WIDTH=64
  logic        iv[2], ir[2], ov[2], ordy[2], oany[2];
  logic [1:0]  rop[2];
  logic [63:0] ra[2], rb[2];
  logic [1:0]  a2, b2, od2, acc2;
  logic [63:0] a64, b64, od64, acc64;

  or_reduce_pipe #(.WIDTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .op(rop[0]),
    .a(a2), .b(b2), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od2),
    .out_any(oany[0]), .acc_q(acc2)
  );

  or_reduce_pipe #(.WIDTH(64)) u_d64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .op(rop[1]),
    .a(a64), .b(b64), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od64),
    .out_any(oany[1]), .acc_q(acc64)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic [63:0] acc;
  } exp_t;

  vec_t tbl[12];
  exp_t sb0[$];
  exp_t sb1[$];
  logic [63:0] macc[2];

  function automatic logic [63:0] mask_of(input int w);
    return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  initial begin
    logic [7:0]  got[$];
    logic [7:0]  stall_exp[4];
    logic [7:0]  stall_a[4];
    logic [7:0]  rst_a[3];
    logic [1:0]  rst_op[3];
    logic [63:0] m, am, bm, r, cur_d, cur_acc;
    exp_t        e;
    int          idx, first;
    logic        in_fire, out_fire;
    string       tag;

    // {op, a, b, expected out_data}; b is non-zero on non-OR2 ops to show it is ignored
    tbl[0]  = '{2'b01, 8'h00, 8'h5A, 8'h00};
    tbl[1]  = '{2'b01, 8'h40, 8'h5A, 8'h01};
    tbl[2]  = '{2'b00, 8'hA0, 8'h05, 8'hA5};
    tbl[3]  = '{2'b11, 8'h77, 8'h5A, 8'h00};
    tbl[4]  = '{2'b10, 8'h01, 8'h5A, 8'h01};
    tbl[5]  = '{2'b10, 8'h10, 8'h5A, 8'h11};
    tbl[6]  = '{2'b10, 8'h80, 8'h5A, 8'h91};
    tbl[7]  = '{2'b01, 8'hFF, 8'h5A, 8'h01};
    tbl[8]  = '{2'b00, 8'h00, 8'h00, 8'h00};
    tbl[9]  = '{2'b01, 8'h80, 8'h5A, 8'h01};
    tbl[10] = '{2'b00, 8'h0F, 8'hF0, 8'hFF};
    tbl[11] = '{2'b01, 8'h01, 8'h5A, 8'h01};

    rst_n = 1'b0;
    iv8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; or8 = 1'b1;
    for (int ch = 0; ch < 2; ch++) begin
      iv[ch] = 1'b0; rop[ch] = '0; ra[ch] = '0; rb[ch] = '0; ordy[ch] = 1'b1; macc[ch] = '0;
    end
    a2 = '0; b2 = '0; a64 = '0; b64 = '0;

    #1;
    chk("reset out_valid", 64'(ov8), 64'd0);
    chk("reset acc_q", 64'(acc8), 64'd0);
    chk("reset out_data", 64'(od8), 64'd0);
    chk("reset out_any", 64'(any8), 64'd0);
    chk("reset in_ready", 64'(ir8), 64'd1);

    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Table: back-to-back, results must appear exactly 3 cycles after acceptance
    for (int c = 0; c < 12 + 3; c++) begin
      if (c < 12) begin
        iv8 = 1'b1; op8 = tbl[c].op; a8 = tbl[c].a; b8 = tbl[c].b;
      end else begin
        iv8 = 1'b0;
      end
      #1;
      if (c >= 3) begin
        chk($sformatf("tbl[%0d] valid", c - 3), 64'(ov8), 64'd1);
        chk($sformatf("tbl[%0d] data", c - 3), 64'(od8), 64'(tbl[c-3].d));
        chk($sformatf("tbl[%0d] any", c - 3), 64'(any8), 64'(tbl[c-3].d != 8'h00));
      end else begin
        chk("tbl lead valid", 64'(ov8), 64'd0);
      end
      @(posedge clk); #1;
    end
    iv8 = 1'b0;
    #1;
    chk("tbl final acc_q", 64'(acc8), 64'h91);
    chk("tbl idle valid", 64'(ov8), 64'd0);
    chk("tbl hold data", 64'(od8), 64'h01);

    // Stall: four REDUCEs, out_ready low for 5 cycles from the first result
    stall_a   = '{8'h01, 8'h00, 8'h80, 8'h24};
    stall_exp = '{8'h01, 8'h00, 8'h01, 8'h01};
    idx = 0; first = -1;
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      if (first < 0 && ov8) first = c;
      or8 = !(first >= 0 && c < first + 5);
      iv8 = (idx < 4);
      op8 = 2'b01;
      a8  = (idx < 4) ? stall_a[idx] : 8'h00;
      b8  = 8'hC3;
      #1;
      if (!or8) chk("stall in_ready", 64'(ir8), 64'd0);
      in_fire  = iv8 && ir8;
      out_fire = ov8 && or8;
      if (out_fire) got.push_back(od8);
      @(posedge clk); #1;
      if (in_fire) idx++;
    end
    iv8 = 1'b0; or8 = 1'b1;
    chk("stall count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stall result %0d", i), (got.size() > i) ? 64'(got[i]) : 64'hDEAD, 64'(stall_exp[i]));
    end

    // Reset with three transactions in flight and a non-zero accumulator
    #1;
    chk("pre-rst acc_q", 64'(acc8), 64'h91);
    rst_op = '{2'b10, 2'b10, 2'b01};
    rst_a  = '{8'h02, 8'h04, 8'h01};
    for (int c = 0; c < 3; c++) begin
      iv8 = 1'b1; op8 = rst_op[c]; a8 = rst_a[c]; b8 = 8'h00;
      @(posedge clk); #1;
    end
    iv8 = 1'b0;
    chk("pre-rst out_valid", 64'(ov8), 64'd1);
    chk("pre-rst acc_q after accum", 64'(acc8), 64'h93);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 64'(ov8), 64'd0);
    chk("async rst acc_q", 64'(acc8), 64'd0);
    chk("async rst out_data", 64'(od8), 64'd0);
    chk("async rst out_any", 64'(any8), 64'd0);
    chk("async rst in_ready", 64'(ir8), 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    // First edge after release must accept
    iv8 = 1'b1; op8 = 2'b00; a8 = 8'hA0; b8 = 8'h05;
    #1;
    chk("post-rst in_ready", 64'(ir8), 64'd1);
    @(posedge clk); #1;
    iv8 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("post-rst valid c%0d", k), 64'(ov8), 64'(k == 3));
      if (k == 3) begin
        chk("post-rst or2 data", 64'(od8), 64'hA5);
        chk("post-rst or2 any", 64'(any8), 64'd1);
      end
      @(posedge clk); #1;
    end
    chk("post-rst acc_q", 64'(acc8), 64'd0);

    // Randomized run on WIDTH=2 and WIDTH=64 against the reference model
    for (int cyc = 0; cyc < 3600; cyc++) begin
      for (int ch = 0; ch < 2; ch++) begin
        iv[ch]   = (cyc < 3000) && ($urandom_range(0, 9) < 7);
        rop[ch]  = 2'($urandom);
        ra[ch]   = {$urandom, $urandom};
        rb[ch]   = {$urandom, $urandom};
        ordy[ch] = (cyc >= 3000) || ($urandom_range(0, 9) < 6);
      end
      // Sparse operands keep REDUCE results mixed between 0 and 1
      if ($urandom_range(0, 3) == 0) ra[1] = 64'd1 << $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) ra[1] = '0;
      a2 = ra[0][1:0]; b2 = rb[0][1:0]; a64 = ra[1]; b64 = rb[1];
      #1;
      for (int ch = 0; ch < 2; ch++) begin
        tag     = (ch == 0) ? "w2" : "w64";
        cur_d   = (ch == 0) ? {62'd0, od2} : od64;
        cur_acc = (ch == 0) ? {62'd0, acc2} : acc64;
        if (ov[ch] && !ordy[ch]) chk({"rand in_ready ", tag}, 64'(ir[ch]), 64'd0);
        if (ov[ch] && ordy[ch]) begin
          if ((ch == 0 && sb0.size() == 0) || (ch == 1 && sb1.size() == 0)) begin
            chk({"rand unexpected output ", tag}, 64'd1, 64'd0);
          end else begin
            e = (ch == 0) ? sb0.pop_front() : sb1.pop_front();
            chk({"rand data ", tag}, cur_d, e.d);
            chk({"rand any ", tag}, 64'(oany[ch]), 64'(e.d != 64'd0));
            chk({"rand acc_q ", tag}, cur_acc, e.acc);
          end
        end
        if (iv[ch] && ir[ch]) begin
          m  = mask_of((ch == 0) ? 2 : 64);
          am = ra[ch] & m;
          bm = rb[ch] & m;
          case (rop[ch])
            2'b00:   r = am | bm;
            2'b01:   r = (am != 64'd0) ? 64'd1 : 64'd0;
            2'b10:   begin macc[ch] = macc[ch] | am; r = macc[ch]; end
            default: begin macc[ch] = 64'd0; r = 64'd0; end
          endcase
          e.d = r; e.acc = macc[ch];
          if (ch == 0) sb0.push_back(e); else sb1.push_back(e);
        end
      end
      @(posedge clk); #1;
      if (cyc >= 3000 && sb0.size() == 0 && sb1.size() == 0 && !ov[0] && !ov[1]) break;
    end
    chk("rand drain w2", 64'(sb0.size()), 64'd0);
    chk("rand drain w64", 64'(sb1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/or_reduce_pipe.md
OR_REDUCE_PIPE -- requirements
Module: or_reduce_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand width; SHALL be a power of two, 2..64; elaboration SHALL fail otherwise.
REQ-002 Derived constant LAT = log2(WIDTH), the pipeline depth in cycles (WIDTH=8 -> 3).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  input transaction present.
REQ-006 in_ready  output  1  block accepts input this cycle.
REQ-007 op  input  2  operation: 00 OR2 (a|b), 01 REDUCE (|a), 10 ACCUM (acc|a), 11 CLEAR.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B; used by OR2 only.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_data  output  WIDTH  result word.
REQ-013 out_any  output  1  OR of all out_data bits.
REQ-014 acc_q  output  WIDTH  current accumulator value.

Function
REQ-015 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-016 stall = out_valid && !out_ready; in_ready SHALL equal !stall, combinationally.
REQ-017 Pipeline SHALL have LAT stages; each stage holds a valid bit, op, and partial results; stage LAT is the output register.
REQ-018 When stall is low, every stage SHALL advance one position per cycle; stage 1 loads the accepted input, or a bubble (valid=0) if there is no transfer.
REQ-019 When stall is high, every stage, including the output register and acc_q, SHALL hold.
REQ-020 Bubbles SHALL NOT be collapsed; latency from input transfer to out_valid SHALL be exactly LAT cycles absent stall, plus one cycle per stalled cycle.
REQ-021 REDUCE: stage k SHALL OR adjacent pairs of level k-1 (a binary tree of depth LAT); out_data = {WIDTH-1 zeros, |a}.
REQ-022 OR2: out_data SHALL equal a|b; operands are carried through all LAT stages unchanged until the bitwise OR in stage LAT.
REQ-023 ACCUM: when the transaction enters stage LAT, out_data SHALL be acc_q|a and acc_q SHALL load that same value.
REQ-024 CLEAR: when the transaction enters stage LAT, out_data SHALL be 0 and acc_q SHALL load 0.
REQ-025 acc_q SHALL change only at stage-LAT entry of ACCUM or CLEAR. Back-to-back ACCUMs SHALL see each predecessor's update, with no hazard.
REQ-026 out_any SHALL be |out_data, derived from the output register, with no extra latency.
REQ-027 Throughput SHALL be one transaction per cycle when out_ready stays high.
REQ-028 Input transfer and output transfer in the same cycle SHALL both complete.
REQ-029 When out_valid is low, out_data and out_any SHALL hold their last values; consumers ignore them.
REQ-030 op SHALL be carried with its transaction; a change of op between consecutive inputs SHALL NOT corrupt in-flight results.

Reset
REQ-031 While rst_n=0, all stage valid bits, out_valid, out_data, out_any and acc_q SHALL be 0 immediately, without waiting for a clock edge.
REQ-032 Reset SHALL discard all in-flight transactions, with no output produced for them.
REQ-033 in_ready SHALL be 1 during and after reset.
REQ-034 Release of rst_n SHALL be synchronised externally. The first input SHALL be accepted on the first rising edge after release.

Verification (WIDTH=8, LAT=3)
REQ-035 REDUCE a=8'h00, then a=8'h40, out_ready=1 -> out_data 8'h00/out_any 0 at cycle 3, then 8'h01/out_any 1 at cycle 4.
REQ-036 OR2 a=8'hA0, b=8'h05 -> out_data 8'hA5, out_any 1, exactly 3 cycles after acceptance.
REQ-037 CLEAR, then ACCUM 8'h01, 8'h10, 8'h80 back-to-back -> out_data 00, 01, 11, 91 on consecutive cycles; final acc_q 8'h91.
REQ-038 Four REDUCE inputs, out_ready held 0 for 5 cycles starting when the first result appears -> in_ready 0 during the stall; no loss or duplication; results in order once out_ready=1.
REQ-039 rst_n pulsed low with 3 transactions in flight and acc_q=8'h91 -> out_valid 0 and acc_q 0 immediately; no stale outputs after release.
REQ-040 Random op/a/b with random out_ready against a reference model for WIDTH=2 (LAT=1) and WIDTH=64 (LAT=6) -> all results match, in order.
